seg_scan_decoder: RTL
=====================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits observed.
REQ-002 Parameter STABLE_CYCLES, default 4: post-sync cycles a (segment, anode) pair must hold unchanged before capture, range 1..255.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous assert, active-low reset.
REQ-005 seg_in  input  7  active-low segments, bit0=a ... bit6=g, driven by an external hex-to-seven-segment driver.
REQ-006 an_in  input  N_DIGITS  active-low digit enables; bit i low selects digit i.
REQ-007 value  output  4*N_DIGITS  last complete frame, digit i in bits [4i+3:4i].
REQ-008 blank  output  N_DIGITS  per-digit blank flag of last complete frame.
REQ-009 frame_valid  output  1  one-cycle pulse when value/blank update.
REQ-010 glyph_err  output  1  one-cycle pulse on capture of an unrecognised pattern.
REQ-011 err_digit  output  clog2(N_DIGITS)  index of the digit that raised glyph_err; holds until next error.

Function
REQ-012 seg_in and an_in SHALL each pass through a 2-flop synchroniser; all later logic uses synchronised values only.
REQ-013 Anode is "valid" when exactly one bit of synchronised an_in is low; zero or multiple low bits are invalid.
REQ-014 FSM states: IDLE, SETTLE, HELD.
REQ-015 IDLE: on valid anode -> SETTLE, stability counter loaded to 1, pair latched.
REQ-016 SETTLE: pair unchanged -> counter increments; pair changed but valid -> restart SETTLE with new pair; anode invalid -> IDLE.
REQ-017 SETTLE: when counter reaches STABLE_CYCLES, capture digit in that cycle -> HELD.
REQ-018 HELD: no further capture until pair changes; change to valid anode -> SETTLE, invalid -> IDLE.
REQ-019 Decode table (active-low hex, seg_in[6:0] -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F.
REQ-020 Pattern 7F decodes as blank: pending blank bit set, pending nibble 0.
REQ-021 Any other pattern: glyph_err pulse next cycle, err_digit = anode index, pending mask bit unchanged.
REQ-022 Recognised or blank capture: store nibble and blank bit in pending buffer at anode index, set pending mask bit; recapture of an already-set digit overwrites it.
REQ-023 When pending mask becomes all-ones: copy pending buffer to value/blank, pulse frame_valid the following cycle, clear mask in same cycle.
REQ-024 Capture-to-frame_valid latency for final digit: exactly 1 cycle; input-to-capture latency: 2 sync cycles + STABLE_CYCLES.
REQ-025 value/blank SHALL change only together with frame_valid.
REQ-026 Stability counter saturates; never wraps.

Reset
REQ-027 rst_n low SHALL immediately force: FSM IDLE, value=0, blank=0, frame_valid=0, glyph_err=0, err_digit=0, pending mask/buffer=0, synchronisers to all-ones (no digit selected).
REQ-028 Reset mid-frame SHALL discard the partial frame; first frame_valid after release requires all N_DIGITS fresh captures.

Verification
REQ-029 Scan digits 0..3 with seg 0x30,0x12,0x08,0x46, each held 10 cycles -> one frame_valid, value=0xCA53, blank=0.
REQ-030 Digit 1 held only STABLE_CYCLES-1 post-sync cycles then anode changes -> no capture for digit 1, no frame_valid that scan.
REQ-031 Digit 2 shows 0x7F -> frame completes with blank=4'b0100, value nibble 2 = 0.
REQ-032 Digit 3 shows 0x55 -> glyph_err pulse, err_digit=3, no frame_valid until a valid digit 3 capture.
REQ-033 an_in=4'b1100 for 20 cycles -> FSM IDLE, no captures, no pulses.
REQ-034 rst_n low after 3 of 4 digits captured, then full rescan -> exactly one frame_valid, with rescanned values only.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Watches the drive lines of a multiplexed, active-low seven-segment display
//   and recovers the hex value being shown. Each (segment, anode) pair must be
//   seen unchanged for STABLE_CYCLES synchronised cycles before its digit is
//   captured. A frame is published once every digit has been captured.
//
// Ports
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   seg_in[6:0]  active-low segments, bit0=a .. bit6=g
//   an_in        active-low digit enables, bit i low selects digit i
//   value        last complete frame, digit i in bits [4i+3:4i]
//   blank        per-digit blank flags of last complete frame
//   frame_valid  one-cycle pulse when value/blank update
//   glyph_err    one-cycle pulse after capture of an unrecognised pattern
//   err_digit    digit index of the most recent glyph_err (held)
//   dbg_state    FSM state: 0=IDLE, 1=SETTLE, 2=HELD
//
// Handshake: there is no flow control. frame_valid and glyph_err are single
// cycle strobes; value/blank/err_digit hold between strobes.
module seg_scan_decoder #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [6:0]                                    seg_in,
  input  logic [N_DIGITS-1:0]                           an_in,
  output logic [4*N_DIGITS-1:0]                         value,
  output logic [N_DIGITS-1:0]                           blank,
  output logic                                          frame_valid,
  output logic                                          glyph_err,
  output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] err_digit,
  output logic [1:0]                                    dbg_state
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  // Synchronisers idle at all-ones: no segment lit, no digit selected.
  logic [6:0]          r_seg_s1, r_seg_s2;
  logic [N_DIGITS-1:0] r_an_s1,  r_an_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_an_s1  <= '1;
      r_an_s2  <= '1;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= an_in;
      r_an_s2  <= r_an_s1;
    end
  end

  logic [N_DIGITS-1:0] w_an_low;
  logic                w_an_valid;
  logic [IW-1:0]       w_an_idx;

  assign w_an_low   = ~r_an_s2;
  assign w_an_valid = ($countones(w_an_low) == 1);

  always_comb begin
    w_an_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_an_low[i]) w_an_idx = IW'(i);
    end
  end

  // Latched pair under observation and its stability count.
  state_t              r_state, w_state_nxt;
  logic [7:0]          r_cnt;
  logic [6:0]          r_seg_l;
  logic [N_DIGITS-1:0] r_an_l;
  logic [IW-1:0]       r_idx_l;
  logic                w_pair_changed;
  logic                w_load, w_inc, w_capture;

  assign w_pair_changed = (r_seg_s2 != r_seg_l) || (r_an_s2 != r_an_l);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_an_valid) begin
          w_state_nxt = ST_SETTLE;
          w_load      = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_pair_changed) begin
          if (w_an_valid) w_load = 1'b1;
          else            w_state_nxt = ST_IDLE;
        end else if (r_cnt >= STABLE_C) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HELD;
        end else begin
          w_inc = 1'b1;
        end
      end
      ST_HELD: begin
        if (w_pair_changed) begin
          if (w_an_valid) begin
            w_state_nxt = ST_SETTLE;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_seg_l <= '1;
      r_an_l  <= '1;
      r_idx_l <= '0;
    end else begin
      if (w_load) begin
        r_cnt   <= 8'd1;
        r_seg_l <= r_seg_s2;
        r_an_l  <= r_an_s2;
        r_idx_l <= w_an_idx;
      end else if (w_inc && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Active-low hex glyph decode; 7F (all off) is a legitimate blank digit.
  logic [3:0] w_nib;
  logic       w_known, w_is_blank;

  always_comb begin
    w_nib      = 4'h0;
    w_known    = 1'b1;
    w_is_blank = 1'b0;
    case (r_seg_l)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      7'h7F: w_is_blank = 1'b1;
      default: w_known = 1'b0;
    endcase
  end

  // Pending frame buffer; published and cleared when the last digit lands.
  logic [4*N_DIGITS-1:0] r_pend_val, w_val_nxt;
  logic [N_DIGITS-1:0]   r_pend_blank, w_blank_nxt;
  logic [N_DIGITS-1:0]   r_mask, w_mask_nxt;
  logic                  w_frame_done, w_err;

  always_comb begin
    w_val_nxt   = r_pend_val;
    w_blank_nxt = r_pend_blank;
    w_mask_nxt  = r_mask;
    if (w_capture && w_known) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (i == int'(r_idx_l)) begin
          w_val_nxt[4*i +: 4] = w_nib;
          w_blank_nxt[i]      = w_is_blank;
          w_mask_nxt[i]       = 1'b1;
        end
      end
    end
  end

  assign w_frame_done = w_capture && w_known && (&w_mask_nxt);
  assign w_err        = w_capture && !w_known;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val   <= '0;
      r_pend_blank <= '0;
      r_mask       <= '0;
      value        <= '0;
      blank        <= '0;
      frame_valid  <= 1'b0;
      glyph_err    <= 1'b0;
      err_digit    <= '0;
    end else begin
      r_pend_val   <= w_val_nxt;
      r_pend_blank <= w_blank_nxt;
      r_mask       <= w_frame_done ? '0 : w_mask_nxt;
      frame_valid  <= w_frame_done;
      glyph_err    <= w_err;
      if (w_frame_done) begin
        value <= w_val_nxt;
        blank <= w_blank_nxt;
      end
      if (w_err) err_digit <= r_idx_l;
    end
  end

  assign dbg_state = r_state;

endmodule
